// File: rtl/grn_pkg.sv
// Shared types and defaults for the GRN result buffer.
package grn_pkg;

    localparam int GRN_RB_DEPTH    = 8;
    localparam int GRN_RB_AFULL_TH = 6;

    typedef logic [511:0] t_grn_word;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } t_acc_state;

endpackage

// File: rtl/grn_result_fifo.sv
// Result storage for grn_result_buffer: memory, read/write pointers and occupancy.
// The head word is read combinationally, so a write is visible the cycle after its edge.
module grn_result_fifo
    import grn_pkg::*;
#(
    parameter int DEPTH = GRN_RB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [511:0]             push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output logic [511:0]             out_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    t_grn_word      mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [LW-1:0]  level_reg;
    logic           pop_fire;

    // Pops against an empty buffer are dropped here, so the caller need not gate them.
    assign pop_fire  = pop && (level_reg != '0);
    assign out_valid = (level_reg != '0);
    assign out_data  = mem[rd_ptr_reg];
    assign level     = level_reg;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop_fire})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/grn_result_buffer.sv
// Result buffer between top_grn and grn_requestor: two-state accept handshake, finish tracking.
// Define GRN_RESULT_BUFFER_STATS_EN to build the words_in/words_out counters.
module grn_result_buffer
    import grn_pkg::*;
#(
    parameter int DEPTH    = GRN_RB_DEPTH,
    parameter int AFULL_TH = GRN_RB_AFULL_TH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_write_in,
    input  logic [511:0]             transient_in,
    output logic                     ack_write_out,
    input  logic                     finish_in,
    output logic                     out_valid,
    output logic [511:0]             out_data,
    input  logic                     out_ready,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     finish_out,
    output logic [31:0]              words_in,
    output logic [31:0]              words_out
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_LVL = LW'(AFULL_TH);

    t_acc_state     state_reg;
    logic           ack_reg;
    logic           finish_seen_reg;
    logic           finish_out_reg;
    logic [LW-1:0]  fifo_level;
    logic           full;
    logic           push;

    // Fullness uses the registered level only: a same-cycle pop never frees a slot early.
    assign full = (fifo_level == FULL_LVL);
    assign push = (state_reg == ST_IDLE) && req_write_in && !full;

    grn_result_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (transient_in),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .level     (fifo_level)
    );

    assign level         = fifo_level;
    assign almost_full   = (fifo_level >= AFULL_LVL);
    assign ack_write_out = ack_reg;
    assign finish_out    = finish_out_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            ack_reg         <= 1'b0;
            finish_seen_reg <= 1'b0;
            finish_out_reg  <= 1'b0;
        end else begin
            ack_reg         <= 1'b0;
            finish_seen_reg <= finish_seen_reg | finish_in;
            case (state_reg)
                ST_IDLE: begin
                    if (push) begin
                        ack_reg   <= 1'b1;
                        state_reg <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
            // A still-pending request holds off finish until it has been accepted and drained.
            if (finish_seen_reg && (fifo_level == '0) && (state_reg == ST_IDLE) && !req_write_in) begin
                finish_out_reg <= 1'b1;
            end
        end
    end

`ifdef GRN_RESULT_BUFFER_STATS_EN
    logic [31:0] words_in_reg;
    logic [31:0] words_out_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            words_in_reg  <= '0;
            words_out_reg <= '0;
        end else begin
            if (push) begin
                words_in_reg <= words_in_reg + 32'd1;
            end
            if (out_valid && out_ready) begin
                words_out_reg <= words_out_reg + 32'd1;
            end
        end
    end

    assign words_in  = words_in_reg;
    assign words_out = words_out_reg;
`else
    assign words_in  = 32'd0;
    assign words_out = 32'd0;
`endif

endmodule

// File: tb/tb_grn_result_buffer.sv
// Scoreboard bench for grn_result_buffer: words are queued when issued, a monitor checks each pop.
module tb_grn_result_buffer;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_write_in;
    logic [511:0]  transient_in;
    logic          ack_write_out;
    logic          finish_in;
    logic          out_valid;
    logic [511:0]  out_data;
    logic          out_ready;
    logic          almost_full;
    logic [3:0]    level;
    logic          finish_out;
    logic [31:0]   words_in;
    logic [31:0]   words_out;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_in   = 0;
    int exp_out  = 0;
    logic [511:0] exp_q [$];

    grn_result_buffer #(.DEPTH(8), .AFULL_TH(6)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_write_in  (req_write_in),
        .transient_in  (transient_in),
        .ack_write_out (ack_write_out),
        .finish_in     (finish_in),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .almost_full   (almost_full),
        .level         (level),
        .finish_out    (finish_out),
        .words_in      (words_in),
        .words_out     (words_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ i;
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each pop (valid & ready at the coming edge) must return the oldest issued word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected no pop", out_data);
            end else begin
                chk("pop_data", out_data, exp_q.pop_front());
                exp_out++;
                $display("pop  data=%0h level=%0d", out_data, level);
            end
        end
    end

    task automatic send_word(input logic [511:0] d, output int waited);
        req_write_in = 1'b1;
        transient_in = d;
        exp_q.push_back(d);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (ack_write_out !== 1'b1 && waited < 8);
        if (ack_write_out !== 1'b1) begin
            chk("ack_timeout", 512'(ack_write_out), 512'd1);
        end else begin
            exp_in++;
        end
        req_write_in = 1'b0;
        $display("push data=%0h wait=%0d level=%0d", d, waited, level);
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (level != 0 && n < 20) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk("drain_level", 512'(level), 512'd0);
    endtask

    function automatic logic [31:0] stat_exp(input int v);
`ifdef GRN_RESULT_BUFFER_STATS_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        req_write_in = 1'b0;
        transient_in = '0;
        finish_in = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_level", 512'(level), 512'd0);
        chk("rst_valid", 512'(out_valid), 512'd0);
        chk("rst_ack", 512'(ack_write_out), 512'd0);
        chk("rst_afull", 512'(almost_full), 512'd0);
        chk("rst_finish", 512'(finish_out), 512'd0);
        chk("rst_words_in", 512'(words_in), 512'd0);

        // Single request: ack one cycle later, word visible at once
        send_word({64{8'hA5}}, w);
        chk("single_wait", 512'(w), 512'd1);
        chk("single_valid", 512'(out_valid), 512'd1);
        chk("single_data", out_data, {64{8'hA5}});
        chk("single_level", 512'(level), 512'd1);
        tick();
        chk("single_ack_pulse", 512'(ack_write_out), 512'd0);
        drain();

        // Eight back-to-back requests fill the buffer, acks two cycles apart
        for (int i = 1; i <= 8; i++) begin
            send_word(mk(i), w);
            chk("fill_wait", 512'(w), (i == 1) ? 512'd1 : 512'd2);
            chk("fill_level", 512'(level), 512'(i));
            chk("fill_afull", 512'(almost_full), (i >= 6) ? 512'd1 : 512'd0);
        end
        req_write_in = 1'b1;
        transient_in = mk(9);
        exp_q.push_back(mk(9));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full_no_ack", 512'(ack_write_out), 512'd0);
        end
        chk("full_level", 512'(level), 512'd8);

        // One-cycle pop: no bypass that edge, pending request acked on the next
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pop_level", 512'(level), 512'd7);
        chk("pop_no_ack", 512'(ack_write_out), 512'd0);
        tick();
        chk("pending_ack", 512'(ack_write_out), 512'd1);
        chk("pending_level", 512'(level), 512'd8);
        exp_in++;
        req_write_in = 1'b0;
        tick();
        drain();

        // Accept and pop in the same cycle at level 3
        for (int i = 20; i < 23; i++) send_word(mk(i), w);
        tick();
        chk("l3_level", 512'(level), 512'd3);
        req_write_in = 1'b1;
        transient_in = mk(23);
        exp_q.push_back(mk(23));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        req_write_in = 1'b0;
        chk("simul_ack", 512'(ack_write_out), 512'd1);
        chk("simul_level", 512'(level), 512'd3);
        exp_in++;
        tick();
        drain();

        // Finish with two words queued: finish_out only after empty, then sticky
        for (int i = 30; i < 32; i++) send_word(mk(i), w);
        tick();
        finish_in = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("fin_level1", 512'(level), 512'd1);
        chk("fin_early1", 512'(finish_out), 512'd0);
        tick();
        out_ready = 1'b0;
        chk("fin_level0", 512'(level), 512'd0);
        chk("fin_early0", 512'(finish_out), 512'd0);
        tick();
        chk("fin_set", 512'(finish_out), 512'd1);
        finish_in = 1'b0;
        repeat (3) tick();
        chk("fin_sticky", 512'(finish_out), 512'd1);
        $display("finish level=%0d finish_out=%0d", level, finish_out);

        // Reset at level 5 discards everything
        for (int i = 40; i < 45; i++) send_word(mk(i), w);
        tick();
        chk("pre_rst_level", 512'(level), 512'd5);
        chk("stat_in", 512'(words_in), 512'(stat_exp(exp_in)));
        chk("stat_out", 512'(words_out), 512'(stat_exp(exp_out)));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        chk("mid_rst_level", 512'(level), 512'd0);
        chk("mid_rst_valid", 512'(out_valid), 512'd0);
        chk("mid_rst_finish", 512'(finish_out), 512'd0);
        chk("mid_rst_words_in", 512'(words_in), 512'd0);
        chk("mid_rst_words_out", 512'(words_out), 512'd0);
        $display("reset level=%0d out_valid=%0d", level, out_valid);

        // Normal operation resumes after reset
        send_word(mk(50), w);
        chk("post_rst_wait", 512'(w), 512'd1);
        chk("post_rst_data", out_data, mk(50));
        tick();
        drain();
        tick();
        chk("q_empty", 512'(exp_q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
